vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//   Generates VGA horizontal/vertical timing and the pixel coordinates for the colour stage.
//   Drives hsync/vsync to the connector; drives ready, x_addr and y_addr to the RGB control logic,
//   which gates its colour outputs with ready.
//   Default timing: 800x600 @ 60 Hz with a 40 MHz pixel clock.
// PARAMETERS
//   H_ACTIVE  800   visible pixels per line
//   H_FRONT   40    horizontal front porch (pixels)
//   H_SYNC    128   hsync pulse width (pixels)
//   H_BACK    88    horizontal back porch (pixels)
//   V_ACTIVE  600   visible lines per frame
//   V_FRONT   1     vertical front porch (lines)
//   V_SYNC    4     vsync pulse width (lines)
//   V_BACK    23    vertical back porch (lines)
//   HS_POL    1     hsync active level (1 = active-high)
//   VS_POL    1     vsync active level
// PORTS
//   clk          in   1   pixel clock; all logic on its rising edge
//   rst          in   1   synchronous reset, active-high
//   pix_en       in   1   pixel advance enable; counters and outputs hold while 0
//   hsync        out  1   horizontal sync, level set by HS_POL
//   vsync        out  1   vertical sync, level set by VS_POL
//   ready        out  1   1 while the current pixel lies in the visible area
//   x_addr       out  11  visible column 0..H_ACTIVE-1; 0 outside the visible area
//   y_addr       out  11  visible line 0..V_ACTIVE-1; 0 outside the visible area
//   line_start   out  1   one-cycle pulse with pixel (h_cnt=0) of every line
//   frame_start  out  1   one-cycle pulse with pixel (0,0) of every frame
// BEHAVIOUR
//   - Constants: H_TOTAL = sum of the H_* parameters (1056); V_TOTAL = sum of the V_* parameters (628).
//     Both totals must be <= 2048.
//   - Internal 11-bit counters h_cnt and v_cnt.
//     Line order: active, front porch, sync, back porch. The frame follows the same order vertically.
//   - Counter update on a clk edge with rst=0 and pix_en=1:
//     h_cnt = (h_cnt==H_TOTAL-1) ? 0 : h_cnt+1.
//     v_cnt advances only when h_cnt wraps, and wraps to 0 at V_TOTAL-1.
//   - Reset (rst=1 at an edge): h_cnt=v_cnt=0; hsync=~HS_POL; vsync=~VS_POL; ready=0; x_addr=0;
//     y_addr=0; line_start=0; frame_start=0.
//     Reset asserted mid-frame aborts the frame immediately; there is no completion of the line.
//   - All outputs are registered and decoded from the pre-increment counter values on edges with pix_en=1.
//     Latency: outputs describe the counter state one cycle earlier.
//     After reset release, the first pix_en=1 edge presents (0,0): ready=1, line_start=1, frame_start=1.
//   - Visible area: vis = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE); ready=vis.
//     x_addr = vis ? h_cnt : 0. y_addr = vis ? v_cnt : 0.
//   - hsync is active when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC, otherwise inactive.
//   - vsync is active when V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC, for whole lines.
//     vsync changes only at line boundaries (h_cnt=0).
//   - line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0).
//   - With pix_en=0 nothing changes, including the outputs.
//     The start pulses therefore stay high while pix_en is low; consumers qualify them with pix_en.
//   - Simultaneous rst and pix_en: rst wins.
// TESTING
//   1. Release reset with pix_en=1 and default parameters.
//      -> First edge gives ready=1, x=0, y=0, frame_start=1, hsync=0, vsync=0.
//      -> x reaches 799 at edge 800; ready=0 from edge 801.
//   2. Run one line.
//      -> hsync high for exactly 128 cycles, starting 840 cycles after line_start.
//      -> line_start period is 1056 cycles; ready high for exactly 800 cycles per line.
//   3. Run one full frame.
//      -> frame_start period is 663168 cycles.
//      -> vsync high for exactly 4*1056 cycles, starting at the line_start of line 601.
//      -> y_addr reaches 599, then stays 0 outside the visible area.
//   4. Toggle pix_en every other cycle.
//      -> All periods double; outputs are stable on pix_en=0 cycles.
//   5. Assert rst for one cycle at x=400, y=300.
//      -> Outputs go to reset values; the next pix_en=1 edge presents (0,0) with frame_start=1.
//   6. Small parameters (H=8/2/2/2, V=4/1/1/1).
//      -> Exhaustive check against a reference model of counters and decode over 3 frames.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Bundle between the VGA timing generator and its consumers (connector pins and RGB stage).
// The generator takes the master modport; the pixel-advance enable flows into it.
interface vga_sync_gen_if;
   logic        pix_en;
   logic        hsync;
   logic        vsync;
   logic        ready;
   logic [10:0] x_addr;
   logic [10:0] y_addr;
   logic        line_start;
   logic        frame_start;

   modport master (
      input  pix_en,
      output hsync, vsync, ready, x_addr, y_addr, line_start, frame_start
   );

   modport slave (
      output pix_en,
      input  hsync, vsync, ready, x_addr, y_addr, line_start, frame_start
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: horizontal/vertical counters, sync pulses and visible-area
// pixel coordinates, all registered and advanced only on pix_en cycles.
module vga_sync_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FRONT  = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BACK   = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FRONT  = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BACK   = 23,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   vga_sync_gen_if.master vga
);
   // Totals must stay within 2048 so that the 11-bit counters can hold every position.
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [11:0] H_VIS_END  = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] V_VIS_END  = 12'(V_ACTIVE);
   localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic [11:0] h_ext;
   logic [11:0] v_ext;
   logic        h_wrap;
   logic        v_wrap;
   logic        vis;
   logic        hs_act;
   logic        vs_act;

   // Decode of the current (pre-increment) position; widened so region ends of 2048 still compare.
   always_comb begin
      h_ext  = {1'b0, h_cnt};
      v_ext  = {1'b0, v_cnt};
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      vis    = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
      hs_act = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
      vs_act = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt           <= '0;
         v_cnt           <= '0;
         vga.hsync       <= ~HS_POL;
         vga.vsync       <= ~VS_POL;
         vga.ready       <= 1'b0;
         vga.x_addr      <= '0;
         vga.y_addr      <= '0;
         vga.line_start  <= 1'b0;
         vga.frame_start <= 1'b0;
      end else if (vga.pix_en) begin
         h_cnt <= h_wrap ? '0 : h_cnt + 11'd1;
         if (h_wrap) begin
            v_cnt <= v_wrap ? '0 : v_cnt + 11'd1;
         end
         vga.hsync       <= hs_act ? HS_POL : ~HS_POL;
         vga.vsync       <= vs_act ? VS_POL : ~VS_POL;
         vga.ready       <= vis;
         vga.x_addr      <= vis ? h_cnt : '0;
         vga.y_addr      <= vis ? v_cnt : '0;
         vga.line_start  <= (h_cnt == '0);
         vga.frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
   end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance checked at hand-picked edges and a
// small-timing instance checked every cycle against a pixel-index model, both via scoreboards.
module tb_vga_sync_gen;
   localparam int S_HA = 8;
   localparam int S_HF = 2;
   localparam int S_HS = 2;
   localparam int S_HB = 2;
   localparam int S_VA = 4;
   localparam int S_VF = 1;
   localparam int S_VS = 1;
   localparam int S_VB = 1;
   localparam int S_HT = 14;
   localparam int S_VT = 7;

   typedef struct {
      int          tag;
      logic [26:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_d;
   logic rst_s;

   int errors = 0;
   int checks = 0;

   exp_t        sb_d[$];
   logic [26:0] sb_s[$];

   always #5 clk = ~clk;

   vga_sync_gen_if dflt_if ();
   vga_sync_gen_if small_if ();

   vga_sync_gen dut_dflt (
      .clk (clk),
      .rst (rst_d),
      .vga (dflt_if)
   );

   vga_sync_gen #(
      .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
      .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
      .HS_POL   (1'b1), .VS_POL  (1'b1)
   ) dut_small (
      .clk (clk),
      .rst (rst_s),
      .vga (small_if)
   );

   function automatic logic [26:0] pack_out(logic hs, logic vs, logic rdy, logic ls, logic fs,
                                            logic [10:0] x, logic [10:0] y);
      return {hs, vs, rdy, ls, fs, x, y};
   endfunction

   function automatic exp_t mk(int tag, logic hs, logic vs, logic rdy, logic ls, logic fs,
                               int x, int y);
      exp_t e;
      e.tag = tag;
      e.val = pack_out(hs, vs, rdy, ls, fs, 11'(x), 11'(y));
      return e;
   endfunction

   // Small-timing expectation for position (h, v), written from the region boundaries.
   function automatic logic [26:0] small_decode(int h, int v);
      logic vis;
      logic hs;
      logic vs;
      vis = (h < S_HA) && (v < S_VA);
      hs  = (h >= S_HA + S_HF) && (h < S_HA + S_HF + S_HS);
      vs  = (v >= S_VA + S_VF) && (v < S_VA + S_VF + S_VS);
      return pack_out(hs, vs, vis, h == 0, (h == 0) && (v == 0),
                      vis ? 11'(h) : 11'd0, vis ? 11'(v) : 11'd0);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Small instance: drive one cycle and push what the model says the DUT will present after it.
   int          s_pix = 0;
   logic [26:0] s_cur = '0;

   task automatic applyStimulus(input bit r, input bit pe);
      @(negedge clk);
      rst_s           = r;
      small_if.pix_en = pe;
      if (r) begin
         s_pix = 0;
         s_cur = pack_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
      end else if (pe) begin
         s_cur = small_decode(s_pix % S_HT, s_pix / S_HT);
         s_pix = (s_pix + 1) % (S_HT * S_VT);
      end
      sb_s.push_back(s_cur);
   endtask

   task automatic runSmall();
      repeat (2) applyStimulus(1'b1, 1'b1);
      repeat (3 * S_HT * S_VT) applyStimulus(1'b0, 1'b1);
      repeat (2 * S_HT * S_VT) begin
         applyStimulus(1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0);
      end
      repeat (45) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);
      repeat (20) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      repeat (30) applyStimulus(1'b0, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   // Default instance: hand-computed values at selected pix_en edges after reset release.
   bit measure_d = 1'b0;

   task automatic applyDefaultStimulus();
      @(negedge clk);
      rst_d          = 1'b1;
      dflt_if.pix_en = 1'b1;
      sb_d.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      sb_d.push_back(mk(1,    0, 0, 1, 1, 1, 0,   0));
      sb_d.push_back(mk(2,    0, 0, 1, 0, 0, 1,   0));
      sb_d.push_back(mk(800,  0, 0, 1, 0, 0, 799, 0));
      sb_d.push_back(mk(801,  0, 0, 0, 0, 0, 0,   0));
      sb_d.push_back(mk(840,  0, 0, 0, 0, 0, 0,   0));
      sb_d.push_back(mk(841,  1, 0, 0, 0, 0, 0,   0));
      sb_d.push_back(mk(968,  1, 0, 0, 0, 0, 0,   0));
      sb_d.push_back(mk(969,  0, 0, 0, 0, 0, 0,   0));
      sb_d.push_back(mk(1056, 0, 0, 0, 0, 0, 0,   0));
      sb_d.push_back(mk(1057, 0, 0, 1, 1, 0, 0,   1));
      sb_d.push_back(mk(2513, 0, 0, 1, 0, 0, 400, 2));
      rst_d     = 1'b0;
      measure_d = 1'b1;
      repeat (2513) @(negedge clk);
      measure_d = 1'b0;
      rst_d     = 1'b1;
      sb_d.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      sb_d.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0));
      sb_d.push_back(mk(2, 0, 0, 1, 0, 0, 1, 0));
      @(negedge clk);
      rst_d = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Default monitor: counts pix_en edges since reset and compares entries whose tag is due.
   int   cnt_d   = 0;
   int   rdy_n   = 0;
   int   hs_n    = 0;
   int   hs_rise = -1;
   logic hs_prev = 1'b0;
   int   ls_q[$];

   always @(posedge clk) begin : mon_dflt
      exp_t e;
      #1;
      if (rst_d) cnt_d = 0;
      else if (dflt_if.pix_en) cnt_d++;
      if (rst_d || dflt_if.pix_en) begin
         while (sb_d.size() > 0 && sb_d[0].tag <= cnt_d) begin
            e = sb_d.pop_front();
            if (e.tag < cnt_d) begin
               checks++;
               errors++;
               $display("[TB] FAIL dflt_edge%0d: not presented, counter already at %0d", e.tag, cnt_d);
            end else begin
               checkOutput($sformatf("dflt_edge%0d", e.tag),
                           32'(pack_out(dflt_if.hsync, dflt_if.vsync, dflt_if.ready,
                                        dflt_if.line_start, dflt_if.frame_start,
                                        dflt_if.x_addr, dflt_if.y_addr)),
                           32'(e.val));
            end
         end
      end
      if (measure_d && !rst_d && dflt_if.pix_en) begin
         if (cnt_d <= 1056) begin
            rdy_n += int'(dflt_if.ready);
            hs_n  += int'(dflt_if.hsync);
            if (dflt_if.hsync && !hs_prev && hs_rise < 0) hs_rise = cnt_d;
         end
         hs_prev = dflt_if.hsync;
         if (dflt_if.line_start && cnt_d <= 2112) ls_q.push_back(cnt_d);
      end
   end

   // Small monitor: the DUT presents a fresh (or held) output on every edge.
   int n_s = 0;

   always @(posedge clk) begin : mon_small
      #1;
      if (sb_s.size() > 0) begin
         checkOutput($sformatf("small_cyc%0d", n_s),
                     32'(pack_out(small_if.hsync, small_if.vsync, small_if.ready,
                                  small_if.line_start, small_if.frame_start,
                                  small_if.x_addr, small_if.y_addr)),
                     32'(sb_s.pop_front()));
         n_s++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ls_first;
      int ls_period;
      rst_d           = 1'b1;
      rst_s           = 1'b1;
      dflt_if.pix_en  = 1'b0;
      small_if.pix_en = 1'b0;
      fork
         applyDefaultStimulus();
         runSmall();
      join
      repeat (2) @(negedge clk);
      ls_first  = (ls_q.size() > 0) ? ls_q[0] : -100000;
      ls_period = (ls_q.size() > 1) ? ls_q[1] - ls_q[0] : -1;
      checkOutput("line_ready_count", 32'(rdy_n), 32'd800);
      checkOutput("line_hsync_count", 32'(hs_n), 32'd128);
      checkOutput("hsync_start_offset", 32'(hs_rise - ls_first), 32'd840);
      checkOutput("line_start_count", 32'(ls_q.size()), 32'd2);
      checkOutput("line_start_period", 32'(ls_period), 32'd1056);
      checkOutput("dflt_queue_drained", 32'(sb_d.size()), 32'd0);
      checkOutput("small_queue_drained", 32'(sb_s.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
